serial_word_assembler: RTL and testbench

- Upstream stage that assembles a qualified serial bit stream into parallel words.
- Presents words to the downstream core-clock consumer over a valid/ready interface, buffered by a small FIFO.
- Detects framing aborts and overflow; optionally checks a trailing parity bit.
- Sits directly ahead of the consumer that samples a clock-domain data qualifier plus data.

---
 rtl/serial_word_assembler.sv | 150 +++++++++++++++
 tb/tb_serial_word_assembler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler with a first-word-fall-through output FIFO.
// Define SERIAL_WORD_ASSEMBLER_PARITY_EN to add a trailing even-parity bit check and parity_err_o.
module serial_word_assembler #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk_core,
  input  logic                  rst_n,
  input  logic                  bit_valid_i,
  input  logic                  bit_data_i,
  input  logic                  frame_start_i,
  output logic                  word_valid_o,
  output logic [WIDTH-1:0]      word_data_o,
  input  logic                  word_ready_i,
  output logic                  abort_o,
  output logic                  overflow_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o,
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  output logic                  parity_err_o,
`endif
  output logic [1:0]            dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;

  state_t                  r_state, w_state_nxt;
  logic [WIDTH-1:0]        r_shift, w_shift_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic                    w_word_done, w_abort, w_par_err;
  logic                    r_abort, r_par_err, r_overflow;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;
  logic [WIDTH-1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]        r_occ;
  logic                    w_full, w_pop, w_push, w_drop;

  // Handshake: a word transfers on any edge where word_valid_o && word_ready_i;
  // the head stays stable while valid is high and ready is low.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_word_done = 1'b0;
    w_abort     = 1'b0;
    w_par_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bit_valid_i && frame_start_i) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = {{(WIDTH-1){1'b0}}, bit_data_i};
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        if (bit_valid_i) begin
          if (frame_start_i) begin
            // Restart mid-word: current bit becomes the new MSB.
            w_abort     = 1'b1;
            w_state_nxt = S_SHIFT;
            w_shift_nxt = {{(WIDTH-1){1'b0}}, bit_data_i};
            w_cnt_nxt   = CNT_W'(1);
          end else if (r_state == S_SHIFT) begin
            w_shift_nxt = {r_shift[WIDTH-2:0], bit_data_i};
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BIT) begin
              w_cnt_nxt = '0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_IDLE;
              w_word_done = 1'b1;
`endif
            end
          end else begin
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
            w_state_nxt = S_IDLE;
            if (^{r_shift, bit_data_i}) w_par_err   = 1'b1;
            else                        w_word_done = 1'b1;
`endif
          end
        end
      end
    endcase
  end

  assign w_full = (r_occ == OCC_W'(FIFO_DEPTH));
  assign w_pop  = word_valid_o && word_ready_i;
  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign w_push = w_word_done && (!w_full || w_pop);
  assign w_drop = w_word_done && !w_push;

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_abort    <= 1'b0;
      r_par_err  <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_cnt     <= w_cnt_nxt;
      r_abort   <= w_abort;
      r_par_err <= w_par_err;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_shift_nxt;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign word_valid_o = (r_occ != '0);
  assign word_data_o  = r_mem[r_rd_ptr];
  assign abort_o      = r_abort;
  assign overflow_o   = r_overflow;
  assign drop_cnt_o   = r_drop_cnt;
  assign dbg_state_o  = r_state;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  assign parity_err_o = r_par_err;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Self-checking bench for serial_word_assembler: vector table, directed corner sequences,
// and randomized traffic checked every cycle against a queue-based reference model.
module tb_serial_word_assembler;

  localparam int WIDTH      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DROP_CNT_W = 8;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                  clk_core;
  logic                  rst_n;
  logic                  bit_valid_i, bit_data_i, frame_start_i, word_ready_i;
  logic                  word_valid_o, abort_o, overflow_o;
  logic [WIDTH-1:0]      word_data_o;
  logic [DROP_CNT_W-1:0] drop_cnt_o;
  logic [1:0]            dbg_state_o;
  logic                  parity_err_o;

  serial_word_assembler #(.WIDTH(WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
    .clk_core      (clk_core),
    .rst_n         (rst_n),
    .bit_valid_i   (bit_valid_i),
    .bit_data_i    (bit_data_i),
    .frame_start_i (frame_start_i),
    .word_valid_o  (word_valid_o),
    .word_data_o   (word_data_o),
    .word_ready_i  (word_ready_i),
    .abort_o       (abort_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    .parity_err_o  (parity_err_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );
`ifndef SERIAL_WORD_ASSEMBLER_PARITY_EN
  assign parity_err_o = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];
  int   m_val, m_cnt, m_drop;
  bit   m_par, m_ovf, m_abort, m_perr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_val = 0; m_cnt = 0; m_drop = 0;
    m_par = 0; m_ovf = 0; m_abort = 0; m_perr = 0;
  endtask

  // One clock: drive inputs, advance the model, then compare all outputs after the edge.
  task automatic step(input logic bv, input logic bd, input logic fs, input logic rdy);
    bit pop, push_req;
    logic [WIDTH-1:0] word;
    bit_valid_i = bv; bit_data_i = bd; frame_start_i = fs; word_ready_i = rdy;
    pop = (exp_q.size() != 0) && rdy;
    push_req = 0; word = '0; m_abort = 0; m_perr = 0;
    if (bv) begin
      if (fs) begin
        m_abort = (m_cnt != 0) || m_par;
        m_val = int'(bd); m_cnt = 1; m_par = 0;
      end else if (m_par) begin
        m_par = 0;
        if ((($countones(m_val) + int'(bd)) % 2) == 0) begin
          push_req = 1; word = WIDTH'(m_val);
        end else m_perr = 1;
      end else if (m_cnt != 0) begin
        m_val = (m_val * 2 + int'(bd)) % (1 << WIDTH);
        m_cnt++;
        if (m_cnt == WIDTH) begin
          m_cnt = 0;
          if (PAR_EN) m_par = 1;
          else begin push_req = 1; word = WIDTH'(m_val); end
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (push_req) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(word);
      else begin
        m_ovf = 1;
        if (m_drop < (1 << DROP_CNT_W) - 1) m_drop++;
      end
    end
    @(posedge clk_core);
    #1;
    chk("valid", 32'(word_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("data", 32'(word_data_o), 32'(exp_q[0]));
    chk("abort", 32'(abort_o), 32'(m_abort));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    chk("parity_err", 32'(parity_err_o), 32'(m_perr && PAR_EN));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    bit_valid_i = 0; bit_data_i = 0; frame_start_i = 0; word_ready_i = 0;
    rst_n = 1'b0;
    #2;
    model_clear();
    @(negedge clk_core);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(word_valid_o), 0);
    chk({tag, "_data"}, 32'(word_data_o), 0);
    chk({tag, "_abort"}, 32'(abort_o), 0);
    chk({tag, "_overflow"}, 32'(overflow_o), 0);
    chk({tag, "_drop"}, 32'(drop_cnt_o), 0);
    chk({tag, "_perr"}, 32'(parity_err_o), 0);
  endtask

  // Sends one framed word; rdy_last applies to the edge that completes it.
  task automatic send_word2(input logic [WIDTH-1:0] w, input logic rdy, input logic rdy_last);
    for (int i = 0; i < WIDTH; i++)
      step(1'b1, w[WIDTH-1-i], i == 0, (i == WIDTH-1 && !PAR_EN) ? rdy_last : rdy);
    if (PAR_EN) step(1'b1, ^w, 1'b0, rdy_last);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy);
    send_word2(w, rdy, rdy);
  endtask

  task automatic drain_expect(input logic [WIDTH-1:0] w, input string name);
    chk({name, "_valid"}, 32'(word_valid_o), 1);
    chk(name, 32'(word_data_o), 32'(w));
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic bv, bd, fs, rdy;
    logic ev;
    logic [WIDTH-1:0] ed;
    logic ea;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic bv, input logic bd, input logic fs, input logic rdy,
                         input logic ev, input logic [WIDTH-1:0] ed, input logic ea);
    vec_t v;
    v.bv = bv; v.bd = bd; v.fs = fs; v.rdy = rdy; v.ev = ev; v.ed = ed; v.ea = ea;
    vecs.push_back(v);
  endtask

  initial begin
    logic [WIDTH-1:0] a6, c3;
    a6 = 8'hA6;
    c3 = 8'h3C;

    rst_n = 1'b0;
    bit_valid_i = 0; bit_data_i = 0; frame_start_i = 0; word_ready_i = 0;
    model_clear();
    #3;
    check_reset_outputs("por");
    @(negedge clk_core);
    rst_n = 1'b1;

    // Single word A6 with one-cycle latency, ignored idle bits, then abort followed by 3C.
    for (int i = 0; i < WIDTH; i++) add_vec(1, a6[WIDTH-1-i], i == 0, 1, i == WIDTH-1, 8'hA6, 0);
    add_vec(0, 0, 0, 1, 0, 8'h00, 0);
    add_vec(1, 1, 0, 1, 0, 8'h00, 0);
    add_vec(1, 0, 0, 1, 0, 8'h00, 0);
    add_vec(1, 1, 1, 1, 0, 8'h00, 0);
    add_vec(1, 0, 0, 1, 0, 8'h00, 0);
    add_vec(1, 1, 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < WIDTH; i++) add_vec(1, c3[WIDTH-1-i], i == 0, 1, i == WIDTH-1, 8'h3C, i == 0);
    add_vec(0, 0, 0, 1, 0, 8'h00, 0);
    if (!PAR_EN) begin
      foreach (vecs[k]) begin
        step(vecs[k].bv, vecs[k].bd, vecs[k].fs, vecs[k].rdy);
        chk("tbl_valid", 32'(word_valid_o), 32'(vecs[k].ev));
        if (vecs[k].ev) chk("tbl_data", 32'(word_data_o), 32'(vecs[k].ed));
        chk("tbl_abort", 32'(abort_o), 32'(vecs[k].ea));
      end
      chk("tbl_overflow", 32'(overflow_o), 0);
    end

    // Overflow: six words into a four-entry FIFO with no reader.
    do_reset();
    for (int k = 1; k <= 6; k++) send_word(WIDTH'(k), 1'b0);
    chk("ovf_sticky", 32'(overflow_o), 1);
    chk("ovf_drop", 32'(drop_cnt_o), 2);
    for (int k = 1; k <= 4; k++) drain_expect(WIDTH'(k), "ovf_drain");
    chk("ovf_empty", 32'(word_valid_o), 0);

    // Drop counter saturation.
    for (int k = 0; k < 260; k++) send_word(WIDTH'(k), 1'b0);
    chk("sat_drop", 32'(drop_cnt_o), 32'hFF);

    // Full FIFO with a pop on the completing edge.
    do_reset();
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    send_word(8'h44, 1'b0);
    send_word2(8'h55, 1'b0, 1'b1);
    chk("fullpop_drop", 32'(drop_cnt_o), 0);
    chk("fullpop_ovf", 32'(overflow_o), 0);
    drain_expect(8'h22, "fullpop_d0");
    drain_expect(8'h33, "fullpop_d1");
    drain_expect(8'h44, "fullpop_d2");
    drain_expect(8'h55, "fullpop_d3");
    chk("fullpop_empty", 32'(word_valid_o), 0);

    // Asynchronous reset mid-word with queued words and an abort pulse showing.
    do_reset();
    send_word(8'h5A, 1'b0);
    send_word(8'hC3, 1'b0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    chk("pre_rst_abort", 32'(abort_o), 1);
    rst_n = 1'b0;
    bit_valid_i = 0; bit_data_i = 0; frame_start_i = 0; word_ready_i = 0;
    #2;
    check_reset_outputs("midrst");
    model_clear();
    @(negedge clk_core);
    rst_n = 1'b1;
    send_word(8'hFF, 1'b1);
    chk("post_rst_valid", 32'(word_valid_o), 1);
    chk("post_rst_data", 32'(word_data_o), 32'hFF);
    step(0, 0, 0, 1);
    chk("post_rst_empty", 32'(word_valid_o), 0);

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    do_reset();
    for (int i = 0; i < WIDTH; i++) step(1, a6[WIDTH-1-i], i == 0, 0);
    step(1, 0, 0, 0);
    chk("par_ok_valid", 32'(word_valid_o), 1);
    chk("par_ok_data", 32'(word_data_o), 32'hA6);
    for (int i = 0; i < WIDTH; i++) step(1, a6[WIDTH-1-i], i == 0, 0);
    step(1, 1, 0, 0);
    chk("par_bad_err", 32'(parity_err_o), 1);
    chk("par_bad_drop", 32'(drop_cnt_o), 0);
    step(0, 0, 0, 0);
    chk("par_err_pulse", 32'(parity_err_o), 0);
    for (int i = 0; i < WIDTH; i++) step(1, a6[WIDTH-1-i], i == 0, 0);
    step(1, 1, 1, 0);
    chk("par_abort", 32'(abort_o), 1);
    drain_expect(8'hA6, "par_drain");
    chk("par_single", 32'(word_valid_o), 0);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 2500; k++)
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 11) == 0,
           $urandom_range(0, 1) == 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
